route_sequencer: RTL and testbench
==================================

Name: route_sequencer

Overview:
- Mission-level controller that drives the black-line follower.
- Holds a small programmable route table with one entry per node: a turn code and an optional pick/place operation.
- Counts debounced node crossings (sensor 111) and presents the correct turn_direction to the follower for each node.
- Enables or stops the follower, and runs the pick/place handshake with the arm controller.

Parameters:
- DEPTH, 16, number of route entries.
- ADDR_W, 4, route pointer width, equal to clog2(DEPTH).
- NODE_DEBOUNCE, 4, consecutive 111 cycles required to declare a node.
- CLEAR_CYCLES, 4, consecutive single-bit sensor cycles (010/001/100) required to declare the node exited.
- OP_TIMEOUT, 50000, maximum cycles to wait for op_done. Counter is 16 bits; OP_TIMEOUT must be at most 65535.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- line_sensor  in  3  same 3-bit pattern fed to the follower.
- start  in  1  one-cycle pulse; begins the route from entry 0.
- abort  in  1  level; forces DONE and stops the robot.
- wr_en  in  1  route table write strobe.
- wr_addr  in  ADDR_W  route table write address.
- wr_data  in  4  route entry: op in [3:2], turn in [1:0].
- op_done  in  1  one-cycle pulse from the arm controller when pick/place completes.
- robot_enabled  out  1  to follower.
- turn_direction  out  2  to follower: 11 straight, 01 left, 10 right, 00 U-turn.
- activate_pick_operation  out  1  to follower and arm.
- activate_place_operation  out  1  to follower and arm.
- route_done  out  1  high in DONE.
- op_error  out  1  sticky; set on op_done timeout.
- step_index  out  ADDR_W  current route pointer.

Behaviour:
- Reset (reset==0 at posedge clk):
  - State=IDLE; ptr=0; all counters=0.
  - robot_enabled=0, turn_direction=11, both activate outputs=0, route_done=0, op_error=0.
  - Route table contents are not reset.
- Op encoding: 00 none, 01 pick, 10 place, 11 end-of-route.
- Table writes:
  - Accepted only in IDLE or DONE.
  - wr_en in RUN/OPERATE/EXIT is ignored; the table is unchanged.
- All outputs are registered. Each output reflects the state that is in effect in the cycle after the transition.
- IDLE:
  - Outputs at reset values.
  - start -> RUN with ptr=0; op_error cleared.
- RUN:
  - robot_enabled=1; turn_direction=table[ptr].turn.
  - node_cnt increments while line_sensor==111 and clears on any other pattern.
  - When node_cnt reaches NODE_DEBOUNCE, the node event fires. The cycle in which the count hits NODE_DEBOUNCE is the event cycle.
  - On the event, by op of table[ptr]:
    - end -> DONE.
    - pick or place -> OPERATE.
    - none -> EXIT.
- OPERATE:
  - The matching activate output (pick or place) is 1 and the other is 0.
  - robot_enabled stays 1; the follower stops itself on activate.
  - turn_direction is held.
  - op_cnt increments each cycle.
  - op_done -> EXIT; activate drops in the following cycle.
  - If op_cnt reaches OP_TIMEOUT with no op_done: op_error=1, then DONE.
- EXIT:
  - turn_direction is held at table[ptr].turn so the follower finishes TURN or U-turn.
  - clr_cnt increments while line_sensor is in {010, 001, 100} and clears otherwise.
  - When clr_cnt reaches CLEAR_CYCLES:
    - If ptr==DEPTH-1 -> DONE; ptr does not wrap.
    - Otherwise ptr++ and -> RUN; node_cnt and clr_cnt cleared.
- DONE:
  - robot_enabled=0, route_done=1, activates=0, turn_direction=11.
  - start -> RUN with ptr=0, route_done=0, op_error cleared.
- abort:
  - From any non-IDLE state, abort forces DONE next cycle and deasserts activates. This is checked before all other transitions.
  - While abort is high, start is ignored.
- Simultaneous events:
  - abort beats op_done and timeout.
  - If op_done arrives in the same cycle the timeout fires, op_done wins: EXIT, no error.
  - A start pulse in RUN/OPERATE/EXIT is ignored.
- Reset mid-route returns to IDLE. The table is retained, so a later start replays the same route.

Decomposition:
- Package route_pkg holds:
  - State encoding, 3 bits: IDLE, RUN, OPERATE, EXIT, DONE.
  - Op codes OP_NONE, OP_PICK, OP_PLACE, OP_END.
  - Turn codes TURN_STRAIGHT, TURN_LEFT, TURN_RIGHT, TURN_UTURN.
  - Sensor constants NODE_PAT=111 and the single-bit line patterns.
- One sub-module, sensor_qualifier:
  - Generic consecutive-match counter: match input, clear input, THRESHOLD parameter, one-cycle hit output.
  - Instantiated twice: once for node debounce, once for node-exit.

Test Plan:
- Load the table with [0]={none,left}, [1]={end,straight}. Pulse start. Drive 010 for 10 cycles, 111 for 4, 001 for 4, then 111 for 4.
  - turn_direction=01 during step 0.
  - step_index=1 after the exit.
  - Then route_done=1 and robot_enabled=0.
- Node glitch: drive 111 for 3 cycles, then 010 -> no node event; step_index stays 0 and state stays RUN.
- Pick: [0]={pick,right}. Drive 111 for 4 cycles.
  - activate_pick_operation=1 and turn_direction=10.
  - Pulse op_done 20 cycles later -> activate is 0 the next cycle. Drive 100 for 4 cycles -> step_index=1.
- Timeout with OP_TIMEOUT=8: [0]={place,straight}, reach the node, withhold op_done.
  - After 8 cycles, op_error=1, route_done=1, and activate_place_operation=0.
- Abort during OPERATE in the same cycle as op_done -> DONE, activates 0, op_error 0.
- A wr_en during RUN does not change the table (verified on replay).
- Reset asserted mid-EXIT -> all outputs return to reset values. Start replays from step 0.
- Final entry: ptr=DEPTH-1 with op none; after exit -> DONE with step_index=DEPTH-1 and no wrap.

Source files
------------

// File: rtl/route_pkg.sv
// Shared encodings for the route sequencer: FSM states, route entry layout,
// turn/op codes and the line-sensor patterns it qualifies.
package route_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN     = 3'd1,
      OPERATE = 3'd2,
      EXIT    = 3'd3,
      DONE    = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_PICK  = 2'b01,
      OP_PLACE = 2'b10,
      OP_END   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      TURN_UTURN    = 2'b00,
      TURN_LEFT     = 2'b01,
      TURN_RIGHT    = 2'b10,
      TURN_STRAIGHT = 2'b11
   } turn_e;

   // Bit layout matches wr_data: op in [3:2], turn in [1:0].
   typedef struct packed {
      op_e   op;
      turn_e turn;
   } entry_t;

   localparam logic [2:0] NODE_PAT    = 3'b111;
   localparam logic [2:0] LINE_LEFT   = 3'b100;
   localparam logic [2:0] LINE_CENTER = 3'b010;
   localparam logic [2:0] LINE_RIGHT  = 3'b001;

   function automatic logic is_single_line(input logic [2:0] pat);
      return (pat == LINE_LEFT) || (pat == LINE_CENTER) || (pat == LINE_RIGHT);
   endfunction

endpackage

// File: rtl/sensor_qualifier.sv
// Consecutive-match counter: o_hit pulses in the cycle the run of i_match
// reaches THRESHOLD; any gap or i_clear restarts the count.
module sensor_qualifier #(
   parameter int THRESHOLD = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_match,
   input  logic i_clear,
   output logic o_hit
);

   localparam int CNT_W = $clog2(THRESHOLD + 1);

   logic [CNT_W-1:0] r_cnt;

   assign o_hit = i_match && !i_clear && (r_cnt == CNT_W'(THRESHOLD - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_clear || !i_match || o_hit) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/route_sequencer.sv
// Mission controller for the line follower: walks a programmable route table
// node by node, steering turns and handshaking pick/place with the arm.
module route_sequencer #(
   parameter int DEPTH         = 16,
   parameter int ADDR_W        = 4,
   parameter int NODE_DEBOUNCE = 4,
   parameter int CLEAR_CYCLES  = 4,
   parameter int OP_TIMEOUT    = 50000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        line_sensor,
   input  logic              start,
   input  logic              abort,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [3:0]        wr_data,
   input  logic              op_done,
   output logic              robot_enabled,
   output logic [1:0]        turn_direction,
   output logic              activate_pick_operation,
   output logic              activate_place_operation,
   output logic              route_done,
   output logic              op_error,
   output logic [ADDR_W-1:0] step_index
);

   import route_pkg::*;

   entry_t            r_table [DEPTH];
   state_e            r_state, w_next_state;
   logic [ADDR_W-1:0] r_ptr, w_next_ptr;
   logic              r_op_error, w_next_error;
   logic [15:0]       r_op_cnt;
   logic              r_robot_enabled, r_pick, r_place, r_route_done;
   logic [1:0]        r_turn;

   logic   w_node_hit, w_clear_hit, w_timeout, w_wr_ok, w_active;
   entry_t w_entry, w_next_entry;

   assign w_entry      = r_table[r_ptr];
   assign w_next_entry = r_table[w_next_ptr];
   assign w_wr_ok      = wr_en && ((r_state == IDLE) || (r_state == DONE));
   assign w_timeout    = (r_state == OPERATE) && (r_op_cnt == 16'(OP_TIMEOUT - 1));

   sensor_qualifier #(.THRESHOLD(NODE_DEBOUNCE)) u_node_qual (
      .clk     (clk),
      .reset   (reset),
      .i_match ((r_state == RUN) && (line_sensor == NODE_PAT)),
      .i_clear (r_state != RUN),
      .o_hit   (w_node_hit)
   );

   sensor_qualifier #(.THRESHOLD(CLEAR_CYCLES)) u_exit_qual (
      .clk     (clk),
      .reset   (reset),
      .i_match ((r_state == EXIT) && is_single_line(line_sensor)),
      .i_clear (r_state != EXIT),
      .o_hit   (w_clear_hit)
   );

   // NOTE: the route table is deliberately left out of reset so a route
   // survives a mid-mission reset and can be replayed.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_table[wr_addr] <= entry_t'(wr_data);
      end
   end

   // NOTE: every always_comb output gets a default first so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_next_ptr   = r_ptr;
      w_next_error = r_op_error;
      if (abort && (r_state != IDLE)) begin
         w_next_state = DONE;
      end else begin
         unique case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  w_next_state = RUN;
                  w_next_ptr   = '0;
                  w_next_error = 1'b0;
               end
            end
            RUN: begin
               if (w_node_hit) begin
                  unique case (w_entry.op)
                     OP_END:           w_next_state = DONE;
                     OP_PICK, OP_PLACE: w_next_state = OPERATE;
                     default:          w_next_state = EXIT;
                  endcase
               end
            end
            OPERATE: begin
               if (op_done) begin
                  w_next_state = EXIT;
               end else if (w_timeout) begin
                  w_next_state = DONE;
                  w_next_error = 1'b1;
               end
            end
            EXIT: begin
               if (w_clear_hit) begin
                  if (r_ptr == ADDR_W'(DEPTH - 1)) begin
                     w_next_state = DONE;
                  end else begin
                     w_next_state = RUN;
                     w_next_ptr   = r_ptr + 1'b1;
                  end
               end
            end
            default: w_next_state = IDLE;
         endcase
      end
   end

   assign w_active = (w_next_state == RUN) || (w_next_state == OPERATE) ||
                     (w_next_state == EXIT);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state         <= IDLE;
         r_ptr           <= '0;
         r_op_error      <= 1'b0;
         r_op_cnt        <= '0;
         r_robot_enabled <= 1'b0;
         r_turn          <= TURN_STRAIGHT;
         r_pick          <= 1'b0;
         r_place         <= 1'b0;
         r_route_done    <= 1'b0;
      end else begin
         r_state         <= w_next_state;
         r_ptr           <= w_next_ptr;
         r_op_error      <= w_next_error;
         r_op_cnt        <= (r_state == OPERATE) ? r_op_cnt + 1'b1 : '0;
         // Outputs are computed from the next state so they line up with it.
         r_robot_enabled <= w_active;
         r_turn          <= w_active ? w_next_entry.turn : TURN_STRAIGHT;
         r_pick          <= (w_next_state == OPERATE) && (w_next_entry.op == OP_PICK);
         r_place         <= (w_next_state == OPERATE) && (w_next_entry.op == OP_PLACE);
         r_route_done    <= (w_next_state == DONE);
      end
   end

   assign robot_enabled            = r_robot_enabled;
   assign turn_direction           = r_turn;
   assign activate_pick_operation  = r_pick;
   assign activate_place_operation = r_place;
   assign route_done               = r_route_done;
   assign op_error                 = r_op_error;
   assign step_index               = r_ptr;

endmodule

// File: tb/tb_route_sequencer.sv
// Directed bench for route_sequencer: two instances share stimulus, one with
// a long op timeout for the handshake paths and one with OP_TIMEOUT=8.
module tb_route_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] line_sensor = 3'b000;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       wr_en = 1'b0;
   logic [3:0] wr_addr = 4'd0;
   logic [3:0] wr_data = 4'd0;
   logic       op_done = 1'b0;

   logic       a_en, a_pick, a_place, a_done, a_err;
   logic [1:0] a_turn;
   logic [3:0] a_step;
   logic       b_en, b_pick, b_place, b_done, b_err;
   logic [1:0] b_turn;
   logic [3:0] b_step;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   route_sequencer #(.OP_TIMEOUT(100)) dut_a (
      .clk(clk), .reset(reset), .line_sensor(line_sensor), .start(start),
      .abort(abort), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .op_done(op_done), .robot_enabled(a_en), .turn_direction(a_turn),
      .activate_pick_operation(a_pick), .activate_place_operation(a_place),
      .route_done(a_done), .op_error(a_err), .step_index(a_step)
   );

   route_sequencer #(.OP_TIMEOUT(8)) dut_b (
      .clk(clk), .reset(reset), .line_sensor(line_sensor), .start(start),
      .abort(abort), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .op_done(op_done), .robot_enabled(b_en), .turn_direction(b_turn),
      .activate_pick_operation(b_pick), .activate_place_operation(b_place),
      .route_done(b_done), .op_error(b_err), .step_index(b_step)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
   endtask

   task automatic write(input logic [3:0] addr, input logic [3:0] data);
      wr_en = 1'b1; wr_addr = addr; wr_data = data;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic drive(input logic [2:0] pat, input int n);
      line_sensor = pat;
      tick(n);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " en"},    a_en,    1'b0);
      check({tag, " turn"},  a_turn,  2'b11);
      check({tag, " pick"},  a_pick,  1'b0);
      check({tag, " place"}, a_place, 1'b0);
      check({tag, " done"},  a_done,  1'b0);
      check({tag, " err"},   a_err,   1'b0);
      check({tag, " step"},  a_step,  4'd0);
   endtask

   initial begin
      // Basic two-node route: none/left then end/straight.
      do_reset();
      check_reset_outputs("reset");
      write(4'd0, 4'b0001);
      write(4'd1, 4'b1111);
      line_sensor = 3'b010;
      pulse_start();
      check("run0 en", a_en, 1'b1);
      check("run0 turn", a_turn, 2'b01);
      drive(3'b010, 10);
      drive(3'b111, 4);
      check("exit0 turn", a_turn, 2'b01);
      check("exit0 step", a_step, 4'd0);
      drive(3'b001, 4);
      check("run1 step", a_step, 4'd1);
      check("run1 turn", a_turn, 2'b11);
      drive(3'b111, 4);
      check("end done", a_done, 1'b1);
      check("end en", a_en, 1'b0);
      check("end turn", a_turn, 2'b11);

      // Node glitch, plus a write attempt during RUN that must be ignored.
      pulse_start();
      drive(3'b111, 3);
      drive(3'b010, 1);
      check("glitch step", a_step, 4'd0);
      check("glitch en", a_en, 1'b1);
      check("glitch turn", a_turn, 2'b01);
      drive(3'b111, 3);
      check("glitch2 turn", a_turn, 2'b01);
      write(4'd1, 4'b0000);
      drive(3'b111, 1);
      drive(3'b010, 4);
      check("nowrite step", a_step, 4'd1);
      check("nowrite turn", a_turn, 2'b11);
      drive(3'b111, 4);
      check("nowrite end", a_done, 1'b1);

      // Pick handshake at entry 0.
      write(4'd0, 4'b0110);
      pulse_start();
      drive(3'b111, 4);
      check("pick act", a_pick, 1'b1);
      check("pick place", a_place, 1'b0);
      check("pick turn", a_turn, 2'b10);
      check("pick en", a_en, 1'b1);
      tick(19);
      check("pick hold", a_pick, 1'b1);
      line_sensor = 3'b100;
      op_done = 1'b1;
      tick();
      op_done = 1'b0;
      check("pick drop", a_pick, 1'b0);
      check("pick exit turn", a_turn, 2'b10);
      check("pick no err", a_err, 1'b0);
      tick(4);
      check("pick step", a_step, 4'd1);

      // Place timeout on the short-timeout instance.
      do_reset();
      write(4'd0, 4'b1011);
      pulse_start();
      drive(3'b111, 4);
      check("to place", b_place, 1'b1);
      tick(7);
      check("to before place", b_place, 1'b1);
      check("to before err", b_err, 1'b0);
      tick();
      check("to err", b_err, 1'b1);
      check("to done", b_done, 1'b1);
      check("to place off", b_place, 1'b0);
      check("to en off", b_en, 1'b0);
      pulse_start();
      check("to restart err", b_err, 1'b0);
      check("to restart done", b_done, 1'b0);

      // Abort coincident with op_done, then start held off by abort.
      do_reset();
      write(4'd0, 4'b0110);
      pulse_start();
      drive(3'b111, 4);
      tick(2);
      abort = 1'b1; op_done = 1'b1;
      tick();
      op_done = 1'b0;
      check("abort done", a_done, 1'b1);
      check("abort pick", a_pick, 1'b0);
      check("abort err", a_err, 1'b0);
      check("abort en", a_en, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("abort start ignored", a_done, 1'b1);

      // Reset mid-EXIT, then replay from step 0.
      do_reset();
      write(4'd0, 4'b0001);
      write(4'd1, 4'b1111);
      pulse_start();
      drive(3'b111, 4);
      drive(3'b010, 2);
      reset = 1'b0;
      tick();
      check_reset_outputs("midreset");
      reset = 1'b1;
      pulse_start();
      check("replay step", a_step, 4'd0);
      check("replay turn", a_turn, 2'b01);
      check("replay en", a_en, 1'b1);

      // Last entry: no wrap past DEPTH-1.
      do_reset();
      for (int i = 0; i < 15; i++) write(4'(i), 4'b0011);
      write(4'd15, 4'b0010);
      pulse_start();
      for (int i = 0; i < 15; i++) begin
         drive(3'b111, 4);
         drive(3'b010, 4);
      end
      check("last step", a_step, 4'd15);
      check("last turn", a_turn, 2'b10);
      check("last en", a_en, 1'b1);
      drive(3'b111, 4);
      drive(3'b010, 4);
      check("last done", a_done, 1'b1);
      check("last nowrap", a_step, 4'd15);
      check("last en off", a_en, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
